// File: rtl/intr_sched_pkg.sv
// Shared types and register map for the machine-level interrupt scheduler.
package intr_sched_pkg;

    typedef enum logic [3:0] {
        IRQ_NONE  = 4'd0,
        IRQ_TIMER = 4'd1,
        IRQ_EXT   = 4'd2
    } irq_code_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_e;

    localparam logic [2:0] ADDR_MTIME_LO    = 3'd0;
    localparam logic [2:0] ADDR_MTIME_HI    = 3'd1;
    localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] ADDR_CTRL        = 3'd4;
    localparam logic [2:0] ADDR_ENABLE      = 3'd5;
    localparam logic [2:0] ADDR_PENDING     = 3'd6;
    localparam logic [2:0] ADDR_CLAIM       = 3'd7;

endpackage

// File: rtl/intr_prio_pick.sv
// External-source winner selection. `INTR_ROUND_ROBIN_EN selects rotating priority
// starting after last_id; otherwise the lowest pending index wins.
module intr_prio_pick #(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0]         pend,
    input  logic [$clog2(NSRC)-1:0] last_id,
    output logic                    valid,
    output logic [$clog2(NSRC)-1:0] id
);
    localparam int IDW = $clog2(NSRC);

    assign valid = |pend;

`ifdef INTR_ROUND_ROBIN_EN
    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        id    = '0;
        found = 1'b0;
        idx   = '0;
        // Walk NSRC slots starting just after last_id; the last slot is last_id itself.
        for (int k = 1; k <= NSRC; k++) begin
            idx = IDW'((int'(last_id) + k) % NSRC);
            if (!found && pend[idx]) begin
                found = 1'b1;
                id    = idx;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last_id;

    always_comb begin
        id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i]) id = IDW'(i);
        end
    end
`endif

endmodule

// File: rtl/intr_sched_ctrl.sv
// Machine interrupt scheduler: mtime/mtimecmp timer, edge-latched external sources,
// single-winner request FSM. Build macro INTR_ROUND_ROBIN_EN enables rotating priority.
module intr_sched_ctrl
    import intr_sched_pkg::*;
#(
    parameter int NSRC     = 8,
    parameter int PRESCALE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         src_irq,
    input  logic                    cfg_we,
    input  logic [2:0]              cfg_addr,
    input  logic [31:0]             cfg_wdata,
    output logic [31:0]             cfg_rdata,
    input  logic                    trap_ack,
    input  logic                    mret,
    output logic [3:0]              irq_code,
    output logic [$clog2(NSRC)-1:0] claim_id
);
    localparam int IDW = $clog2(NSRC);
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PSW-1:0]  ps_cnt;
    logic            tick;
    logic [63:0]     mtime;
    logic [63:0]     mtimecmp;
    logic            timer_en;
    logic            timer_pend;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] sync_p0, sync_p1, sync_p2;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] ack_clr;
    logic            pick_vld;
    logic [IDW-1:0]  pick_id;

    state_e          state_q, state_d;
    irq_code_e       code_q, code_d;
    logic [IDW-1:0]  claim_q, claim_d;
    logic [IDW-1:0]  last_q, last_d;

    assign tick       = (ps_cnt == PSW'(PRESCALE - 1));
    assign timer_pend = timer_en && (mtime >= mtimecmp);

    // Register writes take priority over the free-running increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt   <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
            timer_en <= 1'b0;
            enable   <= '0;
        end else begin
            ps_cnt <= tick ? '0 : ps_cnt + PSW'(1);
            if (cfg_we && cfg_addr == ADDR_MTIME_LO)      mtime[31:0]  <= cfg_wdata;
            else if (cfg_we && cfg_addr == ADDR_MTIME_HI) mtime[63:32] <= cfg_wdata;
            else if (tick)                                mtime        <= mtime + 64'd1;
            if (cfg_we && cfg_addr == ADDR_MTIMECMP_LO) mtimecmp[31:0]  <= cfg_wdata;
            if (cfg_we && cfg_addr == ADDR_MTIMECMP_HI) mtimecmp[63:32] <= cfg_wdata;
            if (cfg_we && cfg_addr == ADDR_CTRL)        timer_en        <= cfg_wdata[0];
            if (cfg_we && cfg_addr == ADDR_ENABLE)      enable          <= cfg_wdata[NSRC-1:0];
        end
    end

    // Source synchroniser (p0/p1) and edge-history stage (p2).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
            pending <= '0;
        end else begin
            sync_p0 <= src_irq;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            pending <= (pending & ~w1c & ~ack_clr) | rise;
        end
    end

    assign rise = sync_p1 & ~sync_p2;
    assign w1c  = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata[NSRC-1:0] : '0;

    intr_prio_pick #(.NSRC(NSRC)) u_pick (
        .pend    (pending & enable),
        .last_id (last_q),
        .valid   (pick_vld),
        .id      (pick_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= IRQ_NONE;
            claim_q <= '0;
            last_q  <= IDW'(NSRC - 1);
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            claim_q <= claim_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        claim_d = claim_q;
        last_d  = last_q;
        ack_clr = '0;
        case (state_q)
            IDLE: begin
                if (timer_pend) begin
                    state_d = REQ;
                    code_d  = IRQ_TIMER;
                end else if (pick_vld) begin
                    state_d = REQ;
                    code_d  = IRQ_EXT;
                    claim_d = pick_id;
                end
            end
            REQ: begin
                if (trap_ack) begin
                    state_d = SERVICE;
                    if (code_q == IRQ_EXT) begin
                        ack_clr[claim_q] = 1'b1;
                        last_d           = claim_q;
                    end
                end
            end
            SERVICE: begin
                if (mret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign irq_code = (state_q == REQ) ? code_q : IRQ_NONE;
    assign claim_id = claim_q;

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_MTIME_LO:    cfg_rdata = mtime[31:0];
            ADDR_MTIME_HI:    cfg_rdata = mtime[63:32];
            ADDR_MTIMECMP_LO: cfg_rdata = mtimecmp[31:0];
            ADDR_MTIMECMP_HI: cfg_rdata = mtimecmp[63:32];
            ADDR_CTRL:        cfg_rdata = {31'd0, timer_en};
            ADDR_ENABLE:      cfg_rdata = 32'(enable);
            ADDR_PENDING:     cfg_rdata = 32'(pending);
            ADDR_CLAIM:       cfg_rdata = {state_q == SERVICE, 31'(claim_q)};
            default:          cfg_rdata = '0;
        endcase
    end

endmodule
